// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared definitions for the register-file writeback controller:
// default widths and depth, the hardwired-zero register address and
// the layout of one buffered writeback entry.
package regfile_wb_ctrl_pkg;

    localparam int DEF_DW    = 8;
    localparam int DEF_AW    = 3;
    localparam int DEF_DEPTH = 4;

    // Register 0 reads as zero and is never written.
    localparam int REG_ZERO  = 0;

    typedef struct packed {
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_ctrl_wb_fifo.sv
// In-order write buffer for the writeback controller. Holds pending
// register writes and exposes every slot in age order (index 0 is the
// oldest) so the bypass search can pick the youngest matching entry.
module wb_fifo
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int DEPTH = DEF_DEPTH
)
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [AW-1:0]                 push_addr,
    input  logic [DW-1:0]                 push_data,
    input  logic                          pop,
    output logic                          full,
    output logic                          empty,
    output logic [AW-1:0]                 head_addr,
    output logic [DW-1:0]                 head_data,
    output logic [DEPTH-1:0]              ent_valid,
    output logic [DEPTH-1:0][AW-1:0]      ent_addr,
    output logic [DEPTH-1:0][DW-1:0]      ent_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_addr = mem_addr[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    // Storage needs no reset: the count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy 0..DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Age-ordered view of the buffer, oldest entry first.
    always_comb begin
        ent_valid = '0;
        ent_addr  = '0;
        ent_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i] = (CW'(i) < count);
            ent_addr[i]  = mem_addr[rd_ptr + PW'(i)];
            ent_data[i]  = mem_data[rd_ptr + PW'(i)];
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller for the 8-entry register file. Accepts results
// over valid/ready, queues them in order, retires one write per enabled
// cycle through a registered write port, and offers a youngest-first
// bypass lookup over everything not yet in the array.
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int DEPTH = DEF_DEPTH
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          res_valid,
    output logic          res_ready,
    input  logic [AW-1:0] res_addr,
    input  logic [DW-1:0] res_data,
    input  logic          drain_en,
    output logic          regwrite,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] wd,
    input  logic [AW-1:0] chk_a1,
    input  logic [AW-1:0] chk_a2,
    output logic          hit1,
    output logic          hit2,
    output logic [DW-1:0] fwd1,
    output logic [DW-1:0] fwd2,
    output logic          idle
);

    logic                     fifo_full;
    logic                     fifo_empty;
    logic [AW-1:0]            head_addr;
    logic [DW-1:0]            head_data;
    logic [DEPTH-1:0]         ent_valid;
    logic [DEPTH-1:0][AW-1:0] ent_addr;
    logic [DEPTH-1:0][DW-1:0] ent_data;
    logic                     accept;
    logic                     push;
    logic                     pop;

    // Ready depends only on registered occupancy, so there is no path
    // from res_valid or drain_en back to res_ready.
    assign res_ready = !fifo_full;
    assign accept    = res_valid && res_ready;

    // Writes to register 0 complete the handshake but are dropped here.
    assign push = accept && (res_addr != AW'(REG_ZERO));
    assign pop  = drain_en && !fifo_empty;

    wb_fifo #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (res_addr),
        .push_data (res_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_addr (head_addr),
        .head_data (head_data),
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr),
        .ent_data  (ent_data)
    );

    // Output stage: one strobe per retired entry, address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite <= 1'b0;
            wa       <= '0;
            wd       <= '0;
        end else if (pop) begin
            regwrite <= 1'b1;
            wa       <= head_addr;
            wd       <= head_data;
        end else begin
            regwrite <= 1'b0;
        end
    end

    // Youngest matching candidate wins: scan from the output stage (oldest)
    // up through the buffer so later matches overwrite earlier ones.
    function automatic logic [DW:0] bypass_lookup(
        input logic [AW-1:0]                 a,
        input logic [DEPTH-1:0]              valids,
        input logic [DEPTH-1:0][AW-1:0]      addrs,
        input logic [DEPTH-1:0][DW-1:0]      datas,
        input logic                          out_valid,
        input logic [AW-1:0]                 out_addr,
        input logic [DW-1:0]                 out_data
    );
        logic [DW:0] result;
        result = '0;
        if (a != AW'(REG_ZERO)) begin
            if (out_valid && (out_addr == a)) begin
                result = {1'b1, out_data};
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (valids[i] && (addrs[i] == a)) begin
                    result = {1'b1, datas[i]};
                end
            end
        end
        return result;
    endfunction

    // Bypass lookup for the first read port.
    always_comb begin
        {hit1, fwd1} = bypass_lookup(chk_a1, ent_valid, ent_addr, ent_data,
                                     regwrite, wa, wd);
    end

    // Bypass lookup for the second read port.
    always_comb begin
        {hit2, fwd2} = bypass_lookup(chk_a2, ent_valid, ent_addr, ent_data,
                                     regwrite, wa, wd);
    end

    assign idle = fifo_empty && !regwrite;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl. Accepted results are pushed
// to an expected-write queue when driven and popped when the DUT raises
// regwrite; bypass and handshake outputs are checked against constants
// and a small occupancy model.
module tb_regfile_wb_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          res_valid = 1'b0;
    logic          res_ready;
    logic [AW-1:0] res_addr = '0;
    logic [DW-1:0] res_data = '0;
    logic          drain_en = 1'b0;
    logic          regwrite;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] chk_a1 = '0;
    logic [AW-1:0] chk_a2 = '0;
    logic          hit1;
    logic          hit2;
    logic [DW-1:0] fwd1;
    logic [DW-1:0] fwd2;
    logic          idle;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   m_count = 0;
    logic exp_rw = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    regfile_wb_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_addr  (res_addr),
        .res_data  (res_data),
        .drain_en  (drain_en),
        .regwrite  (regwrite),
        .wa        (wa),
        .wd        (wd),
        .chk_a1    (chk_a1),
        .chk_a2    (chk_a2),
        .hit1      (hit1),
        .hit2      (hit2),
        .fwd1      (fwd1),
        .fwd2      (fwd2),
        .idle      (idle)
    );

    // Drive one cycle of stimulus, advance the occupancy model and queue
    // the expected write if the offer is accepted.
    task automatic step(input logic d, input logic v, input logic [AW-1:0] a,
                        input logic [DW-1:0] dt, output logic acc);
        logic pop;
        exp_t e;
        drain_en  = d;
        res_valid = v;
        res_addr  = a;
        res_data  = dt;
        acc = v && (m_count != DEPTH);
        pop = d && (m_count != 0);
        @(posedge clk);
        #1;
        if (acc && a != 0) begin
            e.addr = a;
            e.data = dt;
            exp_q.push_back(e);
            m_count++;
        end
        if (pop) m_count--;
        exp_rw = pop;
        res_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({regwrite, wa, wd} !== '0)
            $display("[TB] FAIL reset_outputs: got rw=%b wa=%0d wd=%h want 0/0/00", regwrite, wa, wd);
        else n_pass++;
        n_checks++;
        if (idle !== 1'b1 || res_ready !== 1'b1)
            $display("[TB] FAIL reset_idle_ready: got idle=%b ready=%b want 1/1", idle, res_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        logic acc;
        exp_t e;
        step(1'b1, 1'b1, 3'd5, 8'hA7, acc);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (regwrite !== exp_rw)
                $display("[TB] FAIL single_regwrite cyc %0d: got %b want %b", k, regwrite, exp_rw);
            else n_pass++;
            if (exp_rw && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (wa !== e.addr || wd !== e.data)
                    $display("[TB] FAIL single_write: got wa=%0d wd=%h want wa=%0d wd=%h", wa, wd, e.addr, e.data);
                else n_pass++;
            end
            if (k < 2) step(1'b1, 1'b0, 3'd0, 8'h00, acc);
        end
        n_checks++;
        if (idle !== 1'b1)
            $display("[TB] FAIL single_idle: got %b want 1", idle);
        else n_pass++;
    endtask

    task automatic test_full;
        logic acc;
        logic fifth_done;
        logic exp_ready;
        exp_t e;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, AW'(i + 1), DW'((i + 1) * 17), acc);
        end
        n_checks++;
        if (res_ready !== 1'b0)
            $display("[TB] FAIL full_ready: got %b want 0", res_ready);
        else n_pass++;
        step(1'b0, 1'b1, 3'd5, 8'h55, acc);
        n_checks++;
        if (res_ready !== 1'b0 || regwrite !== 1'b0)
            $display("[TB] FAIL full_hold: got ready=%b rw=%b want 0/0", res_ready, regwrite);
        else n_pass++;
        fifth_done = 1'b0;
        for (int k = 0; k < 7; k++) begin
            exp_ready = (m_count != DEPTH);
            n_checks++;
            if (res_ready !== exp_ready)
                $display("[TB] FAIL full_ready_cyc %0d: got %b want %b", k, res_ready, exp_ready);
            else n_pass++;
            step(1'b1, !fifth_done, 3'd5, 8'h55, acc);
            if (acc) fifth_done = 1'b1;
            n_checks++;
            if (regwrite !== exp_rw)
                $display("[TB] FAIL full_regwrite cyc %0d: got %b want %b", k, regwrite, exp_rw);
            else n_pass++;
            if (exp_rw && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (wa !== e.addr || wd !== e.data)
                    $display("[TB] FAIL full_write cyc %0d: got wa=%0d wd=%h want wa=%0d wd=%h", k, wa, wd, e.addr, e.data);
                else n_pass++;
            end
        end
        n_checks++;
        if (idle !== 1'b1 || exp_q.size() != 0)
            $display("[TB] FAIL full_drained: got idle=%b pending=%0d want 1/0", idle, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_zero;
        logic acc;
        n_checks++;
        if (res_ready !== 1'b1)
            $display("[TB] FAIL zero_ready: got %b want 1", res_ready);
        else n_pass++;
        step(1'b0, 1'b1, 3'd0, 8'hFF, acc);
        chk_a1 = 3'd0;
        #1;
        n_checks++;
        if (idle !== 1'b1 || hit1 !== 1'b0 || fwd1 !== 8'h00)
            $display("[TB] FAIL zero_enqueue: got idle=%b hit1=%b fwd1=%h want 1/0/00", idle, hit1, fwd1);
        else n_pass++;
        step(1'b1, 1'b0, 3'd0, 8'h00, acc);
        n_checks++;
        if (regwrite !== 1'b0)
            $display("[TB] FAIL zero_regwrite: got %b want 0", regwrite);
        else n_pass++;
    endtask

    task automatic test_bypass;
        logic acc;
        exp_t e;
        step(1'b0, 1'b1, 3'd3, 8'h10, acc);
        step(1'b0, 1'b1, 3'd3, 8'h20, acc);
        chk_a1 = 3'd3;
        chk_a2 = 3'd4;
        #1;
        n_checks++;
        if (hit1 !== 1'b1 || fwd1 !== 8'h20)
            $display("[TB] FAIL bypass_fifo_young: got hit1=%b fwd1=%h want 1/20", hit1, fwd1);
        else n_pass++;
        n_checks++;
        if (hit2 !== 1'b0 || fwd2 !== 8'h00)
            $display("[TB] FAIL bypass_miss: got hit2=%b fwd2=%h want 0/00", hit2, fwd2);
        else n_pass++;
        chk_a2 = 3'd3;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 3'd0, 8'h00, acc);
            n_checks++;
            if (regwrite !== exp_rw)
                $display("[TB] FAIL bypass_regwrite cyc %0d: got %b want %b", k, regwrite, exp_rw);
            else n_pass++;
            if (exp_rw && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (wa !== e.addr || wd !== e.data)
                    $display("[TB] FAIL bypass_write cyc %0d: got wa=%0d wd=%h want wa=%0d wd=%h", k, wa, wd, e.addr, e.data);
                else n_pass++;
            end
            n_checks++;
            if (k < 2) begin
                if (hit1 !== 1'b1 || fwd1 !== 8'h20 || hit2 !== 1'b1 || fwd2 !== 8'h20)
                    $display("[TB] FAIL bypass_drain cyc %0d: got hit1=%b fwd1=%h hit2=%b fwd2=%h want 1/20/1/20", k, hit1, fwd1, hit2, fwd2);
                else n_pass++;
            end else begin
                if (hit1 !== 1'b0 || fwd1 !== 8'h00)
                    $display("[TB] FAIL bypass_gone: got hit1=%b fwd1=%h want 0/00", hit1, fwd1);
                else n_pass++;
            end
        end
        chk_a1 = 3'd0;
        chk_a2 = 3'd0;
    endtask

    task automatic test_stream;
        logic acc;
        int   sent;
        int   seen;
        exp_t e;
        sent = 0;
        seen = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            step(1'b1, sent < 10, AW'((sent % 7) + 1), DW'(sent * 19 + 1), acc);
            if (acc) sent++;
            n_checks++;
            if (regwrite !== exp_rw)
                $display("[TB] FAIL stream_regwrite cyc %0d: got %b want %b", cyc, regwrite, exp_rw);
            else n_pass++;
            if (exp_rw && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                seen++;
                n_checks++;
                if (wa !== e.addr || wd !== e.data)
                    $display("[TB] FAIL stream_write cyc %0d: got wa=%0d wd=%h want wa=%0d wd=%h", cyc, wa, wd, e.addr, e.data);
                else n_pass++;
            end
            if (cyc == 6) begin
                n_checks++;
                if (idle !== 1'b0 || res_ready !== 1'b1)
                    $display("[TB] FAIL stream_steady: got idle=%b ready=%b want 0/1", idle, res_ready);
                else n_pass++;
            end
        end
        n_checks++;
        if (seen != 10 || idle !== 1'b1)
            $display("[TB] FAIL stream_total: got writes=%0d idle=%b want 10/1", seen, idle);
        else n_pass++;
    endtask

    task automatic test_reset_midburst;
        logic acc;
        step(1'b0, 1'b1, 3'd6, 8'h61, acc);
        step(1'b0, 1'b1, 3'd7, 8'h72, acc);
        step(1'b0, 1'b1, 3'd2, 8'h23, acc);
        chk_a1 = 3'd6;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({regwrite, wa, wd} !== '0 || idle !== 1'b1 || res_ready !== 1'b1)
            $display("[TB] FAIL midburst_reset: got rw=%b wa=%0d wd=%h idle=%b ready=%b want 0/0/00/1/1", regwrite, wa, wd, idle, res_ready);
        else n_pass++;
        n_checks++;
        if (hit1 !== 1'b0)
            $display("[TB] FAIL midburst_bypass: got hit1=%b want 0", hit1);
        else n_pass++;
        exp_q.delete();
        m_count = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 3'd0, 8'h00, acc);
        n_checks++;
        if (regwrite !== 1'b0 || idle !== 1'b1)
            $display("[TB] FAIL midburst_flushed: got rw=%b idle=%b want 0/1", regwrite, idle);
        else n_pass++;
        chk_a1 = 3'd0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_zero();
        test_bypass();
        test_stream();
        test_reset_midburst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
